// File: rtl/spi_shift_engine.sv
// SPI shift data path: serialises a right-justified tx word onto mosi and assembles miso into a
// right-justified rx word, with frame tracking, rx handshake, overrun and load-collision pulses.
//
// state  | meaning
// IDLE   | no frame in progress; events ignored, mosi holds its last bit
// ACTIVE | frame in progress; shift/sample events move data, counter tracks samples
module spi_shift_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 5
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  load_tx_reg,
    input  logic                  enable,
    input  logic                  lsbfe,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic                  shift_event,
    input  logic                  sample_event,
    input  logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  mosi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  load_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] DW_L = LEN_W'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  lsb_q, lsb_d;
    logic                  mosi_q, mosi_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;
    logic                  load_err_q, load_err_d;

    logic                  start;
    logic                  abort;
    logic                  done;
    logic [LEN_W-1:0]      eff_len;
    logic [DATA_WIDTH-1:0] tx_load;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_mask;

    // Out-of-range lengths fall back to a full-width frame.
    assign eff_len = ((frame_len == '0) || (frame_len > DW_L)) ? DW_L : frame_len;
    // MSB-first words are left-aligned so the first bit always sits at the top.
    assign tx_load = tx_data_in << (DW_L - eff_len);

    assign start = (state_q == IDLE) && load_tx_reg && enable;
    assign abort = (state_q == ACTIVE) && !enable;
    assign done  = (state_q == ACTIVE) && enable && sample_event
                   && (cnt_q == (len_q - LEN_W'(1)));

    assign rx_shift = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
    assign rx_mask  = {DATA_WIDTH{1'b1}} >> (DW_L - len_q);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACTIVE;
            ACTIVE:  if (abort || done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d         = tx_q;
        rx_d         = rx_q;
        rx_data_d    = rx_data_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        lsb_d        = lsb_q;
        mosi_d       = mosi_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        load_err_d   = load_tx_reg && (state_q == ACTIVE);

        if (start) begin
            tx_d   = lsbfe ? tx_data_in : tx_load;
            mosi_d = lsbfe ? tx_data_in[0] : tx_load[DATA_WIDTH-1];
            len_d  = eff_len;
            lsb_d  = lsbfe;
            cnt_d  = '0;
            rx_d   = '0;
        end else if (abort) begin
            cnt_d = '0;
            rx_d  = '0;
        end else if (state_q == ACTIVE) begin
            if (shift_event) begin
                tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_WIDTH-2];
            end
            if (sample_event) begin
                rx_d  = rx_shift;
                cnt_d = cnt_q + LEN_W'(1);
            end
            if (done) begin
                rx_d         = '0;
                cnt_d        = '0;
                rx_data_d    = lsb_q ? (rx_shift >> (DW_L - len_q)) : (rx_shift & rx_mask);
                frame_done_d = 1'b1;
                overrun_d    = rx_valid_q && !rx_ack;
            end
        end

        // A completion in the same cycle as an ack wins: the new word is unread.
        if (done) begin
            rx_valid_d = 1'b1;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_q         <= '0;
            rx_q         <= '0;
            rx_data_q    <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            lsb_q        <= 1'b0;
            mosi_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            rx_data_q    <= rx_data_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            lsb_q        <= lsb_d;
            mosi_q       <= mosi_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rx_data_out = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign mosi        = mosi_q;
    assign busy        = (state_q == ACTIVE);
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign load_err    = load_err_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised SPI data path for the APB SPI core. It serialises a right-justified transmit word onto mosi and deserialises miso into a right-justified receive word. Frame length and bit order are selectable per frame. It adds frame tracking (busy, frame_done), receive handshake (rx_valid/rx_ack), overrun and load-collision reporting, and abort on enable loss. It sits between the baud/clock generator (which supplies shift_event/sample_event) and the register slice.

Parameters:
DATA_WIDTH, 16, maximum frame length in bits; sizes the tx/rx shift registers and data ports (must be >=2).
LEN_W, 5, width of frame_len; must hold DATA_WIDTH.

Ports:
PCLK  input  1  system clock; all state on rising edge.
PRESETn  input  1  asynchronous active-low reset.
load_tx_reg  input  1  one-cycle request to start a frame with tx_data_in.
enable  input  1  SPI enable; low aborts any active frame.
lsbfe  input  1  1 = LSB first, 0 = MSB first; latched at load.
frame_len  input  LEN_W  bits per frame; latched at load.
shift_event  input  1  advance mosi to next bit.
sample_event  input  1  capture miso.
miso  input  1  serial receive data.
tx_data_in  input  DATA_WIDTH  transmit word, right-justified.
rx_ack  input  1  consumer has read rx_data_out.
rx_data_out  output  DATA_WIDTH  last completed receive word, right-justified, zero-extended.
rx_valid  output  1  rx_data_out holds unread data.
mosi  output  1  serial transmit data.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse at frame completion.
overrun  output  1  one-cycle pulse: completion while rx_valid set and not acked.
load_err  output  1  one-cycle pulse: load_tx_reg while busy.

Behaviour:
- Reset: all outputs 0, shift registers 0, bit counter 0, state IDLE. This is asynchronous and applies mid-frame too.
- States: IDLE (busy=0) and ACTIVE (busy=1). Registered outputs; busy asserts the cycle after load.
- Effective length N: frame_len; 0 or >DATA_WIDTH -> DATA_WIDTH. Latched with lsbfe at load; later changes are ignored until the next load.
- IDLE + load_tx_reg + enable=1 -> ACTIVE. Counter=0. The tx register is loaded as follows:
  - LSB first: tx_data_in, and mosi=tx_data_in[0].
  - MSB first: tx_data_in shifted left by DATA_WIDTH-N, and mosi=tx_data_in[N-1].
- Load while enable=0 is ignored.
- ACTIVE + shift_event:
  - LSB first: mosi<=tx[1], tx shifts right, zero fill.
  - MSB first: mosi<=tx[DATA_WIDTH-2], tx shifts left, zero fill.
- ACTIVE + sample_event:
  - MSB first: rx<={rx[DW-2:0],miso}.
  - LSB first: rx<={miso,rx[DW-1:1]}.
  - Counter increments on each sample.
- shift_event and sample_event in the same cycle: both apply, using pre-edge register values.
- Completion is the cycle the Nth sample_event is accepted. On the next edge:
  - state -> IDLE, frame_done=1, rx_valid=1.
  - rx_data_out <= final rx word, with the new bit included; MSB first: low N bits; LSB first: shifted right by DATA_WIDTH-N. Upper bits are 0.
  - rx shift register clears to 0.
- Events in IDLE are ignored. mosi holds its last value until the next load.
- rx_ack clears rx_valid. If completion and rx_ack occur in the same cycle, rx_valid stays 1 with no overrun.
- Completion with rx_valid=1 and no rx_ack: overrun pulses and rx_data_out is overwritten with the new word.
- load_tx_reg while ACTIVE: ignored; load_err pulses. The frame continues unaffected. Load in the completion cycle also counts as collision.
- enable falls while ACTIVE: on the next edge, state -> IDLE, counter=0, rx shift register=0, no frame_done. rx_data_out and rx_valid are unchanged; mosi holds.
- Last shift_event after the final sample: ignored if it arrives after the return to IDLE.

Test Plan:
- DW=16, N=16, MSB first, tx=0xA5C3, miso loops back from mosi, 16 shift/sample pairs -> mosi sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; rx_data_out=0xA5C3, frame_done 1 pulse, busy low next cycle.
- N=8, LSB first, tx=0x00B2, miso driven 1,1,0,1,0,0,0,0 -> mosi 0,1,0,0,1,1,0,1; rx_data_out=0x000B.
- frame_len=0 and frame_len=20 -> both run 16 sample_events before frame_done. frame_len changed mid-frame to 4 -> still 16 samples.
- Two back-to-back frames, no rx_ack -> overrun pulses once, rx_data_out = second word. Repeat with rx_ack in the completion cycle -> no overrun, rx_valid=1.
- load_tx_reg at sample 5 of an active frame -> load_err pulse, original data completes unchanged.
- enable dropped after sample 7 -> busy=0 next cycle, no frame_done, rx_data_out keeps prior value. PRESETn low mid-frame -> all outputs 0 immediately.
